stove_input_conditioner: RTL and testbench

//   Multi-channel debouncer and key-event generator for stove front-panel buttons.

---
 rtl/stove_input_conditioner.sv | 147 ++++++++++++++
 tb/tb_stove_input_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stove_input_conditioner.sv
// Multi-channel button conditioner: per channel a 2-FF synchroniser, a
// stability filter and a hold/auto-repeat FSM producing one-cycle key events.
module stove_input_conditioner #(
  parameter int CHANNELS      = 4,
  parameter int TIME_TO_WAIT  = 500000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                clk,
  input  logic                async_nreset,
  input  logic [CHANNELS-1:0] signal_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] hold_pulse
);

  localparam int CW   = $clog2(TIME_TO_WAIT + 1);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic          INV      = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIME_TO_WAIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [HW-1:0] HOLD_V   = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] REP_V    = HW'(REPEAT_CYCLES);
  localparam logic [HW-1:0] HCNT_ONE = HW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } hold_state_e;

  // Inverting ahead of the synchroniser keeps idle-high active-low pins at
  // "not pressed" straight out of reset, so no spurious press appears.
  logic [CHANNELS-1:0] pressed_raw;
  assign pressed_raw = signal_in ^ {CHANNELS{INV}};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          release_q;
    logic          hold_q;
    logic [HW-1:0] hcnt_q;
    hold_state_e   state_q;
    logic          rise;
    logic          fall;

    // Any cycle where the synchronised input agrees with the level restarts
    // the count, so only an uninterrupted run of TIME_TO_WAIT cycles flips it.
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // ---- synchroniser, filter and edge pulses
    always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        level_q   <= 1'b0;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync1_q   <= pressed_raw[c];
        sync2_q   <= sync1_q;
        level_q   <= level_d;
        cnt_q     <= cnt_d;
        press_q   <= rise;
        release_q <= fall;
      end
    end

    // ---- hold / auto-repeat FSM; a release always wins over a due hold pulse
    always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
        state_q <= IDLE;
        hcnt_q  <= '0;
        hold_q  <= 1'b0;
      end else begin
        hold_q <= 1'b0;
        if (fall) begin
          state_q <= IDLE;
          hcnt_q  <= '0;
        end else begin
          case (state_q)
            IDLE: begin
              hcnt_q <= '0;
              if (rise) begin
                state_q <= PRESSED;
                hcnt_q  <= HCNT_ONE;
              end
            end
            PRESSED: begin
              if (hcnt_q == HOLD_V) begin
                hold_q  <= 1'b1;
                state_q <= HELD;
                hcnt_q  <= HCNT_ONE;
              end else begin
                hcnt_q <= hcnt_q + HCNT_ONE;
              end
            end
            HELD: begin
              // With repeat disabled the counter stays frozen until release.
              if (REPEAT_CYCLES != 0) begin
                if (hcnt_q == REP_V) begin
                  hold_q <= 1'b1;
                  hcnt_q <= HCNT_ONE;
                end else begin
                  hcnt_q <= hcnt_q + HCNT_ONE;
                end
              end
            end
            default: begin
              state_q <= IDLE;
              hcnt_q  <= '0;
            end
          endcase
        end
      end
    end

    assign level_out[c]     = level_q;
    assign press_pulse[c]   = press_q;
    assign release_pulse[c] = release_q;
    assign hold_pulse[c]    = hold_q;
  end

endmodule

// File: tb/tb_stove_input_conditioner.sv
// Scoreboard bench: two instances (active-high with repeat, active-low without
// repeat); expected key events are queued by stimulus and popped by monitors.
module tb_stove_input_conditioner;

  typedef struct packed {
    int         cyc;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] hd;
    logic [1:0] lv;
  } ev_t;

  logic       clk = 1'b0;
  logic       async_nreset = 1'b0;
  logic [1:0] sig_a = 2'b00;
  logic [1:0] sig_b = 2'b11;
  logic [1:0] la, pa, ra, ha;
  logic [1:0] lb, pb, rb, hb;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t qa[$];
  ev_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stove_input_conditioner #(
    .CHANNELS(2), .TIME_TO_WAIT(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(5), .ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .async_nreset(async_nreset), .signal_in(sig_a),
    .level_out(la), .press_pulse(pa), .release_pulse(ra), .hold_pulse(ha)
  );

  stove_input_conditioner #(
    .CHANNELS(2), .TIME_TO_WAIT(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(0), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .async_nreset(async_nreset), .signal_in(sig_b),
    .level_out(lb), .press_pulse(pb), .release_pulse(rb), .hold_pulse(hb)
  );

  function automatic ev_t mk(input int c, input logic [1:0] pr, input logic [1:0] rl,
                             input logic [1:0] hd, input logic [1:0] lv);
    ev_t e;
    e.cyc = c; e.pr = pr; e.rl = rl; e.hd = hd; e.lv = lv;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Monitor for instance A
  always @(negedge clk) begin
    ev_t e;
    while (qa.size() > 0 && qa[0].cyc < cyc) begin
      e = qa.pop_front();
      checks++; errors++;
      $display("FAIL a_missing expected event at cyc=%0d (now %0d)", e.cyc, cyc);
    end
    if ((pa | ra | ha) != 2'b00) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected cyc=%0d pr=%b rl=%b hd=%b lv=%b", cyc, pa, ra, ha, la);
      end else begin
        e = qa.pop_front();
        if (e.cyc != cyc || e.pr !== pa || e.rl !== ra || e.hd !== ha || e.lv !== la) begin
          errors++;
          $display("FAIL a_event got cyc=%0d pr=%b rl=%b hd=%b lv=%b exp cyc=%0d pr=%b rl=%b hd=%b lv=%b",
                   cyc, pa, ra, ha, la, e.cyc, e.pr, e.rl, e.hd, e.lv);
        end
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    ev_t e;
    while (qb.size() > 0 && qb[0].cyc < cyc) begin
      e = qb.pop_front();
      checks++; errors++;
      $display("FAIL b_missing expected event at cyc=%0d (now %0d)", e.cyc, cyc);
    end
    if ((pb | rb | hb) != 2'b00) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected cyc=%0d pr=%b rl=%b hd=%b lv=%b", cyc, pb, rb, hb, lb);
      end else begin
        e = qb.pop_front();
        if (e.cyc != cyc || e.pr !== pb || e.rl !== rb || e.hd !== hb || e.lv !== lb) begin
          errors++;
          $display("FAIL b_event got cyc=%0d pr=%b rl=%b hd=%b lv=%b exp cyc=%0d pr=%b rl=%b hd=%b lv=%b",
                   cyc, pb, rb, hb, lb, e.cyc, e.pr, e.rl, e.hd, e.lv);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    int e1;

    // Reset with idle inputs on both instances, then 20 quiet cycles
    repeat (3) tick();
    async_nreset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("a_idle", {la, pa, ra, ha}, 8'h00);
      chk("b_idle", {lb, pb, rb, hb}, 8'h00);
    end

    // Ch0 clean press then release before the hold time
    e0 = cyc;
    sig_a[0] = 1'b1;
    qa.push_back(mk(e0 + 6, 2'b01, 2'b00, 2'b00, 2'b01));
    wait_until(e0 + 8);
    chk("a_level_held", {6'b0, la}, 8'h01);
    e1 = cyc;
    sig_a[0] = 1'b0;
    qa.push_back(mk(e1 + 6, 2'b00, 2'b01, 2'b00, 2'b00));
    wait_until(e1 + 10);

    // Ch0 bouncing: 3 high / 1 low never survives the filter
    for (int r = 0; r < 5; r++) begin
      sig_a[0] = 1'b1;
      repeat (3) tick();
      sig_a[0] = 1'b0;
      tick();
    end
    repeat (8) tick();
    chk("a_glitch_level", {6'b0, la}, 8'h00);

    // Ch1 long press with repeats; release lands on a due repeat cycle
    e0 = cyc;
    sig_a[1] = 1'b1;
    qa.push_back(mk(e0 + 6,  2'b10, 2'b00, 2'b00, 2'b10));
    qa.push_back(mk(e0 + 16, 2'b00, 2'b00, 2'b10, 2'b10));
    qa.push_back(mk(e0 + 21, 2'b00, 2'b00, 2'b10, 2'b10));
    qa.push_back(mk(e0 + 26, 2'b00, 2'b00, 2'b10, 2'b10));
    wait_until(e0 + 25);
    sig_a[1] = 1'b0;
    qa.push_back(mk(e0 + 31, 2'b00, 2'b10, 2'b00, 2'b00));
    wait_until(e0 + 45);
    chk("a_after_release", {la, pa, ra, ha}, 8'h00);

    // Both channels together, then reset in the middle of HELD
    e0 = cyc;
    sig_a = 2'b11;
    qa.push_back(mk(e0 + 6,  2'b11, 2'b00, 2'b00, 2'b11));
    qa.push_back(mk(e0 + 16, 2'b00, 2'b00, 2'b11, 2'b11));
    wait_until(e0 + 18);
    chk("a_level_before_reset", {6'b0, la}, 8'h03);
    async_nreset = 1'b0;
    #1;
    chk("a_reset_clear", {la, pa, ra, ha}, 8'h00);
    chk("b_reset_clear", {lb, pb, rb, hb}, 8'h00);
    repeat (3) tick();
    sig_a = 2'b00;
    async_nreset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("a_post_reset", {la, pa, ra, ha}, 8'h00);
    end

    // Active-low instance: ch0 driven low, single hold pulse, no repeat
    e0 = cyc;
    sig_b[0] = 1'b0;
    qb.push_back(mk(e0 + 6,  2'b01, 2'b00, 2'b00, 2'b01));
    qb.push_back(mk(e0 + 16, 2'b00, 2'b00, 2'b01, 2'b01));
    wait_until(e0 + 40);
    chk("b_level_held", {6'b0, lb}, 8'h01);
    e1 = cyc;
    sig_b[0] = 1'b1;
    qb.push_back(mk(e1 + 6, 2'b00, 2'b01, 2'b00, 2'b00));
    wait_until(e1 + 12);
    chk("b_after_release", {lb, pb, rb, hb}, 8'h00);

    chk("a_queue_empty", 8'(qa.size()), 8'h00);
    chk("b_queue_empty", 8'(qb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
